// File: rtl/uart_tx_arbiter_if.sv
// Handshake and uart_tx-facing bus of the arbiter: requester side plus the tx port.
// master = arbiter side, slave = requesters / uart_tx side.
interface uart_tx_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    localparam int GID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    tx_start;
    logic [DATA_W-1:0]       tx_data;
    logic                    tx_busy;
    logic [GID_W-1:0]        grant_id;
    logic                    active;
    logic                    timeout;

    modport master (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_start, tx_data, grant_id, active, timeout
    );

    modport slave (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_start, tx_data, grant_id, active, timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one uart_tx among N_REQ byte producers; one byte per grant, frame tracked via tx_busy.
// Optional busy-rise watchdog enabled by defining TXARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_W     = 8,
    parameter int START_HOLD = 2,
    parameter int BUSY_WAIT  = 16
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_arbiter_if.master  bus
);
    localparam int GID_W  = $clog2(N_REQ);
    localparam int HOLD_W = $clog2(START_HOLD + 1);

    if (N_REQ < 2 || N_REQ > 8 || START_HOLD < 1 || BUSY_WAIT < 1) begin : g_bad_param
        $error("uart_tx_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [GID_W-1:0]   rr_ptr;
    logic [GID_W-1:0]   next_ptr;
    logic [GID_W-1:0]   pick_idx;
    logic               pick_vld;
    logic               accept;
    logic               frame_end;
    logic               timeout_hit;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               hold_done;

    // Priority scan starting at rr_ptr; iterating downward lets the nearest valid index win.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
                pick_vld = 1'b1;
                pick_idx = GID_W'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end

    assign accept    = (state == IDLE) && !bus.tx_busy && pick_vld && !reset;
    assign hold_done = (hold_cnt == HOLD_W'(START_HOLD - 1));
    assign next_ptr  = (int'(bus.grant_id) == N_REQ - 1) ? '0 : bus.grant_id + GID_W'(1);
    assign frame_end = ((state == WAIT_DONE) && !bus.tx_busy) || timeout_hit;

`ifdef TXARB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(BUSY_WAIT + 1);
    logic [WAIT_W-1:0] wait_cnt;

    // Busy has priority over the watchdog when both land on the same cycle.
    assign timeout_hit = (state == WAIT_BUSY) && !bus.tx_busy &&
                         (wait_cnt == WAIT_W'(BUSY_WAIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt    <= '0;
            bus.timeout <= 1'b0;
        end else begin
            wait_cnt    <= (state == WAIT_BUSY) ? wait_cnt + WAIT_W'(1) : '0;
            bus.timeout <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (accept) next_state = START;
            START:     if (hold_done) next_state = WAIT_BUSY;
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    next_state = WAIT_DONE;
                end else if (timeout_hit) begin
                    next_state = IDLE;
                end
            end
            WAIT_DONE: if (!bus.tx_busy) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.active    = (state != IDLE);
        bus.req_ready = accept ? (N_REQ'(1) << pick_idx) : '0;
    end

    // tx_start is a flop that mirrors the upcoming START state, so it rises the cycle after accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr       <= '0;
            hold_cnt     <= '0;
            bus.tx_start <= 1'b0;
            bus.tx_data  <= '0;
            bus.grant_id <= '0;
        end else begin
            bus.tx_start <= (next_state == START);
            hold_cnt     <= (state == START) ? hold_cnt + HOLD_W'(1) : '0;
            if (accept) begin
                bus.tx_data  <= bus.req_data[int'(pick_idx) * DATA_W +: DATA_W];
                bus.grant_id <= pick_idx;
            end
            if (frame_end) begin
                rr_ptr <= next_ptr;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; uart_tx is modelled by driving tx_busy from the bench.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(4), .DATA_W(8)) bus();

    uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .START_HOLD(2), .BUSY_WAIT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        reset = 1'b1;
        bus.req_valid = '0;
        bus.tx_busy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // Complete frame: accept, START_HOLD=2 start pulse, busy high 4 cycles, busy falls.
    task automatic frame(input logic [3:0] vld, input int exp_idx, input logic [7:0] exp_dat,
                         input bit hold, input string name);
        logic [3:0] exp_rdy;
        exp_rdy = 4'b0001 << exp_idx;
        bus.req_valid = vld;
        bus.tx_busy = 1'b0;
        #1;
        checks++; if (bus.req_ready !== exp_rdy) begin errors++;
            $display("FAIL %s ready: got %b want %b", name, bus.req_ready, exp_rdy); end
        @(posedge clk); #1;
        if (!hold) bus.req_valid = '0;
        checks++; if (bus.tx_start !== 1'b1) begin errors++;
            $display("FAIL %s start1: got %b want 1", name, bus.tx_start); end
        checks++; if (bus.tx_data !== exp_dat) begin errors++;
            $display("FAIL %s data: got %h want %h", name, bus.tx_data, exp_dat); end
        checks++; if (bus.grant_id !== 2'(exp_idx)) begin errors++;
            $display("FAIL %s grant: got %0d want %0d", name, bus.grant_id, exp_idx); end
        checks++; if (bus.req_ready !== 4'b0000 || bus.active !== 1'b1) begin errors++;
            $display("FAIL %s busy_state: ready %b active %b want 0000 1", name, bus.req_ready, bus.active); end
        @(posedge clk); #1;
        checks++; if (bus.tx_start !== 1'b1) begin errors++;
            $display("FAIL %s start2: got %b want 1", name, bus.tx_start); end
        @(posedge clk); #1;
        checks++; if (bus.tx_start !== 1'b0) begin errors++;
            $display("FAIL %s start_fall: got %b want 0", name, bus.tx_start); end
        bus.tx_busy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (bus.active !== 1'b1 || bus.tx_data !== exp_dat) begin errors++;
            $display("FAIL %s hold: active %b data %h want 1 %h", name, bus.active, bus.tx_data, exp_dat); end
        bus.tx_busy = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.active !== 1'b0) begin errors++;
            $display("FAIL %s done: active %b want 0", name, bus.active); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_data = 32'h11223344;
        bus.tx_busy = 1'b0;
        #12;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++;
            $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
        checks++; if (bus.tx_start !== 1'b0 || bus.tx_data !== 8'h00 || bus.grant_id !== 2'd0) begin errors++;
            $display("FAIL reset_regs: start %b data %h grant %0d want 0 00 0", bus.tx_start, bus.tx_data, bus.grant_id); end
        checks++; if (bus.active !== 1'b0 || bus.timeout !== 1'b0) begin errors++;
            $display("FAIL reset_flags: active %b timeout %b want 0 0", bus.active, bus.timeout); end
        apply_reset();
    endtask

    task automatic test_single();
        bus.req_data = 32'h00000066;
        frame(4'b0001, 0, 8'h66, 1'b0, "single");
    endtask

    task automatic test_round_robin();
        apply_reset();
        bus.req_data = 32'hA3A2A1A0;
        for (int i = 0; i < 5; i++) begin
            frame(4'b1111, i % 4, 8'hA0 + 8'(i % 4), 1'b1, "round_robin");
        end
        bus.req_valid = '0;
    endtask

    task automatic test_busy_blocking();
        bus.tx_busy = 1'b1;
        bus.req_valid = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.req_ready !== 4'b0000 || bus.active !== 1'b0) begin errors++;
                $display("FAIL busy_block: ready %b active %b want 0000 0", bus.req_ready, bus.active); end
        end
        bus.tx_busy = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++;
            $display("FAIL busy_release: got %b want 0100", bus.req_ready); end
        frame(4'b0100, 2, 8'hA2, 1'b0, "busy_frame");
        // Withdrawn request while blocked must never be sent.
        bus.tx_busy = 1'b1;
        bus.req_valid = 4'b0001;
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;
        bus.tx_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.tx_start !== 1'b0 || bus.active !== 1'b0) begin errors++;
                $display("FAIL withdrawn: start %b active %b want 0 0", bus.tx_start, bus.active); end
        end
    endtask

    task automatic test_reset_mid_frame();
        // rr_ptr is 3 here; requester 1 is taken and the frame is aborted.
        bus.req_valid = 4'b0010;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++;
            $display("FAIL abort_ready: got %b want 0010", bus.req_ready); end
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        bus.tx_busy = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.active !== 1'b1) begin errors++;
            $display("FAIL abort_wait_done: active %b want 1", bus.active); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.tx_start !== 1'b0 || bus.active !== 1'b0 || bus.req_ready !== 4'b0000) begin errors++;
            $display("FAIL abort_async: start %b active %b ready %b want 0 0 0000", bus.tx_start, bus.active, bus.req_ready); end
        bus.tx_busy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.tx_start !== 1'b0 || bus.active !== 1'b0) begin errors++;
                $display("FAIL abort_reissue: start %b active %b want 0 0", bus.tx_start, bus.active); end
        end
        frame(4'b1010, 1, 8'hA1, 1'b0, "after_reset");
    endtask

    task automatic test_loopback_byte();
        bus.req_data[23:16] = 8'h5A;
        frame(4'b0100, 2, 8'h5A, 1'b0, "req2_5a");
    endtask

    task automatic test_timeout();
        int n;
        int seen;
        // rr_ptr is 3 here, so requester 0 is next for a lone request on it.
        bus.req_valid = 4'b0001;
        bus.tx_busy = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = '0;
        checks++; if (bus.grant_id !== 2'd0) begin errors++;
            $display("FAIL to_grant: got %0d want 0", bus.grant_id); end
        repeat (2) @(posedge clk);
        #1;
`ifdef TXARB_TIMEOUT_EN
        n = 0;
        seen = 0;
        while (n < 40 && seen == 0) begin
            @(posedge clk); #1;
            n++;
            if (bus.timeout === 1'b1) seen = 1;
        end
        checks++; if (seen != 1 || n != 16) begin errors++;
            $display("FAIL to_latency: seen %0d cycles %0d want 1 16", seen, n); end
        checks++; if (bus.active !== 1'b0) begin errors++;
            $display("FAIL to_idle: active %b want 0", bus.active); end
        @(posedge clk); #1;
        checks++; if (bus.timeout !== 1'b0) begin errors++;
            $display("FAIL to_pulse: timeout %b want 0", bus.timeout); end
`else
        seen = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            if (bus.timeout !== 1'b0) seen = 1;
        end
        n = int'(bus.active);
        checks++; if (seen != 0 || n != 1) begin errors++;
            $display("FAIL no_timeout: seen %0d active %0d want 0 1", seen, n); end
        bus.tx_busy = 1'b1;
        @(posedge clk); #1;
        bus.tx_busy = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.active !== 1'b0) begin errors++;
            $display("FAIL no_timeout_done: active %b want 0", bus.active); end
`endif
        frame(4'b1111, 1, 8'hA1, 1'b0, "post_timeout");
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.tx_busy = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_busy_blocking();
        test_reset_mid_frame();
        test_loopback_byte();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
